dcache_assoc_ctrl: RTL

//  Parametrised N-way set-associative, write-back/write-allocate data cache controller.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_lru.sv | 50 +++++
 rtl/dcache_assoc_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the set-associative data cache controller.
package dcache_pkg;

    localparam int unsigned OFS_W = 5;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StAllocate,
        StRefill
    } state_e;

    function automatic int unsigned idx_w(int unsigned sets);
        return unsigned'($clog2(sets));
    endfunction

    function automatic int unsigned tag_w(int unsigned sets);
        return 32 - OFS_W - idx_w(sets);
    endfunction

    // A direct-mapped build still needs a 1-bit way select to keep vectors non-empty.
    function automatic int unsigned way_w(int unsigned ways);
        return (ways > 1) ? unsigned'($clog2(ways)) : 1;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age tracker: one age per way per set; 0 = most recent, WAYS-1 = victim.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int unsigned SETS = 16,
    parameter int unsigned WAYS = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     touch_i,
    input  logic [idx_w(SETS)-1:0]   set_i,
    input  logic [way_w(WAYS)-1:0]   way_i,
    output logic [way_w(WAYS)-1:0]   lru_way_o
);
    localparam int unsigned WayW = way_w(WAYS);

    logic [SETS-1:0][WAYS-1:0][WayW-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (touch_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WayW'(w) == way_i) begin
                    age_d[set_i][w] = '0;
                end else if (age_q[set_i][w] < age_q[set_i][way_i]) begin
                    age_d[set_i][w] = age_q[set_i][w] + WayW'(1);
                end
            end
        end
        lru_way_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[set_i][w] == WayW'(WAYS - 1)) begin
                lru_way_o = WayW'(w);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WayW'(w);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// N-way set-associative write-back/write-allocate data cache controller with true-LRU
// replacement and saturating hit/miss counters.
module dcache_assoc_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned SETS   = 16,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);
    localparam int unsigned IdxW = idx_w(SETS);
    localparam int unsigned TagW = tag_w(SETS);
    localparam int unsigned WayW = way_w(WAYS);

    state_e                                 state_q, state_d;
    logic [SETS-1:0][WAYS-1:0]              valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0]              dirty_q, dirty_d;
    logic [SETS-1:0][WAYS-1:0][TagW-1:0]    tag_q, tag_d;
    logic [SETS-1:0][WAYS-1:0][LINE_W-1:0]  data_q, data_d;
    logic [WayW-1:0]                        victim_q, victim_d;
    logic                                   replay_q, replay_d;
    logic                                   mem_enable_q, mem_enable_d;
    logic                                   mem_write_q, mem_write_d;
    logic [31:0]                            mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]                      mem_data_q, mem_data_d;
    logic [CNT_W-1:0]                       hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]                       miss_cnt_q, miss_cnt_d;

    logic [IdxW-1:0] idx;
    logic [TagW-1:0] tag;
    logic [2:0]      word;
    logic            req, hit_any, inv_any, lru_touch;
    logic [WayW-1:0] hit_way, inv_way, lru_way, victim;
    logic            unused_addr;

    assign idx         = cpu_addr_i[OFS_W +: IdxW];
    assign tag         = cpu_addr_i[31 -: TagW];
    assign word        = cpu_addr_i[4:2];
    assign req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign unused_addr = ^cpu_addr_i[1:0];

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit_any = 1'b1;
                hit_way = WayW'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_any = 1'b1;
                inv_way = WayW'(w);
            end
        end
    end

    assign victim      = inv_any ? inv_way : lru_way;
    assign cpu_data_o  = data_q[idx][hit_way][{word, 5'd0} +: 32];
    assign cpu_stall_o = req && !(state_q == StIdle && hit_any);

    if (WAYS > 1) begin : g_lru
        dcache_lru #(
            .SETS (SETS),
            .WAYS (WAYS)
        ) u_lru (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .touch_i   (lru_touch),
            .set_i     (idx),
            .way_i     (hit_way),
            .lru_way_o (lru_way)
        );
    end else begin : g_no_lru
        logic unused_touch;
        assign unused_touch = lru_touch;
        assign lru_way      = '0;
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        victim_d     = victim_q;
        replay_d     = 1'b0;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        lru_touch    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && hit_any) begin
                    lru_touch = 1'b1;
                    // The post-refill replay was already counted as a miss.
                    if (!replay_q && hit_cnt_q != {CNT_W{1'b1}}) begin
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end
                    if (cpu_MemWrite_i) begin
                        data_d[idx][hit_way][{word, 5'd0} +: 32] = cpu_data_i;
                        dirty_d[idx][hit_way] = 1'b1;
                    end
                end else if (req) begin
                    if (miss_cnt_q != {CNT_W{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                    victim_d = victim;
                    if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                        state_d     = StWriteback;
                        mem_addr_d  = {tag_q[idx][victim], idx, 5'd0};
                        mem_data_d  = data_q[idx][victim];
                        mem_write_d = 1'b1;
                    end else begin
                        state_d     = StAllocate;
                        mem_addr_d  = {tag, idx, 5'd0};
                        mem_write_d = 1'b0;
                    end
                end
            end
            StWriteback: begin
                if (mem_enable_q && mem_ack_i) begin
                    state_d      = StAllocate;
                    mem_enable_d = 1'b0;
                    mem_addr_d   = {tag, idx, 5'd0};
                    mem_write_d  = 1'b0;
                end else begin
                    mem_enable_d = 1'b1;
                end
            end
            StAllocate: begin
                if (mem_enable_q && mem_ack_i) begin
                    state_d                = StRefill;
                    mem_enable_d           = 1'b0;
                    tag_d[idx][victim_q]   = tag;
                    valid_d[idx][victim_q] = 1'b1;
                    dirty_d[idx][victim_q] = 1'b0;
                    data_d[idx][victim_q]  = mem_data_i;
                end else begin
                    mem_enable_d = 1'b1;
                end
            end
            StRefill: begin
                state_d  = StIdle;
                replay_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            dirty_q      <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            victim_q     <= '0;
            replay_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            victim_q     <= victim_d;
            replay_q     <= replay_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule
